// File: rtl/sum_display_if.sv
// Handshake and display bundle between the adder-side master and sum_display.
interface sum_display_if #(
   parameter int W = 5
);
   logic         start;
   logic [W-1:0] sum_in;
   logic         busy;
   logic         done;
   logic [3:0]   bcd_tens;
   logic [3:0]   bcd_ones;
   logic [6:0]   seg;
   logic [3:0]   an;
   logic         dp;

   modport master (
      output start, sum_in,
      input  busy, done, bcd_tens, bcd_ones,
      input  seg, an, dp
   );

   modport slave (
      input  start, sum_in,
      output busy, done, bcd_tens, bcd_ones,
      output seg, an, dp
   );
endinterface

// File: rtl/sum_display.sv
// Double-dabble BCD conversion of the adder sum and 2-digit multiplexed display.
// Define DP_CARRY_EN to light the ones-slot decimal point from the latched carry bit.
module sum_display #(
   parameter int W            = 5,
   parameter int REFRESH_BITS = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   sum_display_if.slave bus
);

   localparam int CW = $clog2(W + 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_INIT = CW'(W);
   localparam logic [REFRESH_BITS-1:0] REF_ONE = REFRESH_BITS'(1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t                  r_state;
   logic [W-1:0]            r_sh;
   logic [7:0]              r_scr;
   logic [CW-1:0]           r_cnt;
   logic                    r_busy;
   logic                    r_done;
   logic [3:0]              r_tens;
   logic [3:0]              r_ones;
   logic [REFRESH_BITS-1:0] r_refresh;

   logic [7:0]              w_adj;
   logic [7:0]              w_scr_nxt;
   logic                    w_sel_tens;
   logic [3:0]              w_digit;
   logic [3:0]              w_an;
   logic [6:0]              w_seg;
   logic                    w_dp;

   function automatic logic [6:0] f_dec(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   // Add-3 correction precedes the shift so no nibble ever exceeds 9
   always_comb begin
      w_adj[3:0] = (r_scr[3:0] >= 4'd5) ? r_scr[3:0] + 4'd3 : r_scr[3:0];
      w_adj[7:4] = (r_scr[7:4] >= 4'd5) ? r_scr[7:4] + 4'd3 : r_scr[7:4];
      w_scr_nxt  = {w_adj[6:0], r_sh[W-1]};
   end

`ifdef DP_CARRY_EN
   logic r_cap_c;
   logic r_carry;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_sh    <= '0;
         r_scr   <= '0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_tens  <= '0;
         r_ones  <= '0;
`ifdef DP_CARRY_EN
         r_cap_c <= 1'b0;
         r_carry <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_sh    <= bus.sum_in;
                  r_scr   <= '0;
                  r_cnt   <= CNT_INIT;
                  r_busy  <= 1'b1;
                  r_state <= SHIFT;
`ifdef DP_CARRY_EN
                  r_cap_c <= bus.sum_in[W-1];
`endif
               end
            end
            SHIFT: begin
               r_scr <= w_scr_nxt;
               r_sh  <= {r_sh[W-2:0], 1'b0};
               r_cnt <= r_cnt - CNT_ONE;
               if (r_cnt == CNT_ONE) begin
                  r_tens  <= w_scr_nxt[7:4];
                  r_ones  <= w_scr_nxt[3:0];
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
`ifdef DP_CARRY_EN
                  r_carry <= r_cap_c;
`endif
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_refresh <= '0;
      else        r_refresh <= r_refresh + REF_ONE;
   end

   // Tens slot is blanked (anode off) when the tens digit is zero
   always_comb begin
      w_sel_tens = r_refresh[REFRESH_BITS-1];
      w_digit    = w_sel_tens ? r_tens : r_ones;
      if (!w_sel_tens) begin
         w_an  = 4'b1110;
         w_seg = f_dec(w_digit);
      end else if (r_tens == 4'd0) begin
         w_an  = 4'b1111;
         w_seg = 7'b1111111;
      end else begin
         w_an  = 4'b1101;
         w_seg = f_dec(w_digit);
      end
`ifdef DP_CARRY_EN
      w_dp = !(r_carry && !w_sel_tens);
`else
      w_dp = 1'b1;
`endif
   end

   assign bus.busy     = r_busy;
   assign bus.done     = r_done;
   assign bus.bcd_tens = r_tens;
   assign bus.bcd_ones = r_ones;
   assign bus.seg      = w_seg;
   assign bus.an       = w_an;
   assign bus.dp       = w_dp;

endmodule

// File: tb/tb_sum_display.sv
// Directed bench for sum_display: conversion timing, BCD values, display mux, reset abort.
module tb_sum_display;

   localparam int W = 5;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   int n_chk = 0;
   int n_fail = 0;

   sum_display_if #(.W(W)) bus ();

   sum_display #(.W(W), .REFRESH_BITS(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic convert(input logic [W-1:0] v);
      bus.sum_in = v;
      bus.start  = 1'b1;
      tick();
      bus.start  = 1'b0;
      repeat (W) tick();
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.sum_in = '0;
      repeat (2) tick();
      n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", bus.busy); end
      n_chk++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b want 0", bus.done); end
      n_chk++; if (bus.bcd_tens !== 4'd0) begin n_fail++; $display("FAIL rst_tens got %0d want 0", bus.bcd_tens); end
      n_chk++; if (bus.bcd_ones !== 4'd0) begin n_fail++; $display("FAIL rst_ones got %0d want 0", bus.bcd_ones); end
      n_chk++; if (bus.an !== 4'b1110) begin n_fail++; $display("FAIL rst_an got %b want 1110", bus.an); end
      n_chk++; if (bus.seg !== 7'b1000000) begin n_fail++; $display("FAIL rst_seg got %b want 1000000", bus.seg); end
      n_chk++; if (bus.dp !== 1'b1) begin n_fail++; $display("FAIL rst_dp got %b want 1", bus.dp); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_sum23;
      int bad, seen_t, seen_o;
      bus.sum_in = 5'd23;
      bus.start  = 1'b1;
      tick();
      bus.start  = 1'b0;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad++;
         if (i < 4) tick();
      end
      n_chk++; if (bad != 0) begin n_fail++; $display("FAIL s23_busy_window got %0d bad cycles want 0", bad); end
      tick();
      n_chk++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL s23_done got %b want 1", bus.done); end
      n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL s23_busy_end got %b want 0", bus.busy); end
      n_chk++; if (bus.bcd_tens !== 4'd2) begin n_fail++; $display("FAIL s23_tens got %0d want 2", bus.bcd_tens); end
      n_chk++; if (bus.bcd_ones !== 4'd3) begin n_fail++; $display("FAIL s23_ones got %0d want 3", bus.bcd_ones); end
      tick();
      n_chk++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL s23_done_pulse got %b want 0", bus.done); end
      bad = 0; seen_t = 0; seen_o = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.an === 4'b1101) begin
            seen_t++;
            if (bus.seg !== 7'b0100100) bad++;
         end else if (bus.an === 4'b1110) begin
            seen_o++;
            if (bus.seg !== 7'b0110000) bad++;
         end else bad++;
         tick();
      end
      n_chk++; if (bad != 0) begin n_fail++; $display("FAIL s23_seg got %0d bad samples want 0", bad); end
      n_chk++; if (seen_t == 0 || seen_o == 0) begin
         n_fail++; $display("FAIL s23_slots got tens=%0d ones=%0d want both >0", seen_t, seen_o);
      end
   endtask

   task automatic test_blank;
      int low, bad;
      convert(5'd7);
      n_chk++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL s7_done got %b want 1", bus.done); end
      n_chk++; if (bus.bcd_tens !== 4'd0) begin n_fail++; $display("FAIL s7_tens got %0d want 0", bus.bcd_tens); end
      n_chk++; if (bus.bcd_ones !== 4'd7) begin n_fail++; $display("FAIL s7_ones got %0d want 7", bus.bcd_ones); end
      low = 0; bad = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.an[1] !== 1'b1) low++;
         if (bus.an === 4'b1110 && bus.seg !== 7'b1111000) bad++;
         tick();
      end
      n_chk++; if (low != 0) begin n_fail++; $display("FAIL s7_blank got %0d an1-low samples want 0", low); end
      n_chk++; if (bad != 0) begin n_fail++; $display("FAIL s7_seg got %0d bad samples want 0", bad); end
      convert(5'd31);
      n_chk++; if (bus.bcd_tens !== 4'd3) begin n_fail++; $display("FAIL s31_tens got %0d want 3", bus.bcd_tens); end
      n_chk++; if (bus.bcd_ones !== 4'd1) begin n_fail++; $display("FAIL s31_ones got %0d want 1", bus.bcd_ones); end
      tick();
   endtask

   task automatic test_back_to_back;
      int extra;
      bus.sum_in = 5'd12;
      bus.start  = 1'b1;
      tick();
      bus.sum_in = 5'd9;
      extra = 0;
      for (int k = 1; k <= 11; k++) begin
         tick();
         if (k == 5) begin
            n_chk++; if (bus.done !== 1'b1 || bus.bcd_tens !== 4'd1 || bus.bcd_ones !== 4'd2) begin
               n_fail++; $display("FAIL b2b_first got done=%b %0d%0d want done=1 12", bus.done, bus.bcd_tens, bus.bcd_ones);
            end
         end else if (k == 11) begin
            n_chk++; if (bus.done !== 1'b1 || bus.bcd_tens !== 4'd0 || bus.bcd_ones !== 4'd9) begin
               n_fail++; $display("FAIL b2b_second got done=%b %0d%0d want done=1 09", bus.done, bus.bcd_tens, bus.bcd_ones);
            end
         end else if (bus.done !== 1'b0) extra++;
         if (k == 6 && bus.busy !== 1'b1) extra++;
      end
      bus.start = 1'b0;
      n_chk++; if (extra != 0) begin n_fail++; $display("FAIL b2b_timing got %0d stray events want 0", extra); end
      tick();
      n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got busy=%b want 0", bus.busy); end
   endtask

   task automatic test_reset_abort;
      int stray;
      bus.sum_in = 5'd19;
      bus.start  = 1'b1;
      tick();
      bus.start  = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      n_chk++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         n_fail++; $display("FAIL abort_flags got busy=%b done=%b want 0 0", bus.busy, bus.done);
      end
      n_chk++; if (bus.bcd_tens !== 4'd0 || bus.bcd_ones !== 4'd0) begin
         n_fail++; $display("FAIL abort_bcd got %0d%0d want 00", bus.bcd_tens, bus.bcd_ones);
      end
      n_chk++; if (bus.an !== 4'b1110 || bus.seg !== 7'b1000000 || bus.dp !== 1'b1) begin
         n_fail++; $display("FAIL abort_disp got an=%b seg=%b dp=%b want 1110 1000000 1", bus.an, bus.seg, bus.dp);
      end
      stray = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (i == 2) rst_n = 1'b1;
         if (bus.done !== 1'b0 || bus.busy !== 1'b0) stray++;
      end
      n_chk++; if (stray != 0) begin n_fail++; $display("FAIL abort_nodone got %0d stray cycles want 0", stray); end
      convert(5'd19);
      n_chk++; if (bus.done !== 1'b1 || bus.bcd_tens !== 4'd1 || bus.bcd_ones !== 4'd9) begin
         n_fail++; $display("FAIL abort_restart got done=%b %0d%0d want done=1 19", bus.done, bus.bcd_tens, bus.bcd_ones);
      end
      tick();
   endtask

   task automatic test_dp;
      int bad;
      convert(5'd16);
      n_chk++; if (bus.bcd_tens !== 4'd1 || bus.bcd_ones !== 4'd6) begin
         n_fail++; $display("FAIL dp16_bcd got %0d%0d want 16", bus.bcd_tens, bus.bcd_ones);
      end
      bad = 0;
      for (int i = 0; i < 40; i++) begin
`ifdef DP_CARRY_EN
         if (bus.an === 4'b1110 && bus.dp !== 1'b0) bad++;
         if (bus.an !== 4'b1110 && bus.dp !== 1'b1) bad++;
`else
         if (bus.dp !== 1'b1) bad++;
`endif
         tick();
      end
      n_chk++; if (bad != 0) begin n_fail++; $display("FAIL dp16 got %0d bad samples want 0", bad); end
      convert(5'd15);
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.dp !== 1'b1) bad++;
         tick();
      end
      n_chk++; if (bad != 0) begin n_fail++; $display("FAIL dp15 got %0d bad samples want 0", bad); end
   endtask

   initial begin
      bus.start  = 1'b0;
      bus.sum_in = '0;
      test_reset();
      test_sum23();
      test_blank();
      test_back_to_back();
      test_reset_abort();
      test_dp();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
